aes_byte_bridge: RTL and testbench



---
 rtl/aes_bridge_pkg.sv | 9 +
 rtl/aes_bridge_txser.sv | 37 +++
 rtl/aes_byte_bridge.sv | 138 +++++++++++++
 tb/tb_aes_byte_bridge.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_bridge_pkg.sv
// aes_bridge_pkg: shared states and command-byte layout for the aes byte bridge
package aes_bridge_pkg;
  typedef enum logic [2:0] {IDLE, ADDR, WDATA, ACCESS, TX} state_e;
  localparam int CMD_WR_BIT = 7;
  localparam int CMD_RSV_MSB = 6;
  localparam int CMD_RSV_LSB = 4;
  localparam int CMD_BURST_W = 4;
  localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/aes_bridge_txser.sv
// aes_bridge_txser: 32-to-8 MSB-first read word serializer with valid/ready handshake
module aes_bridge_txser
  import aes_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        done
);
  logic [31:0] sh_q, sh_d;
  logic [1:0] cnt_q, cnt_d;
  logic vld_q, vld_d;
  logic hs;
  assign hs = vld_q && tx_ready;
  assign done = hs && cnt_q == 2'(BYTES_PER_WORD - 1);
  assign tx_data = sh_q[31:24];
  assign tx_valid = vld_q;
  always_comb begin
    sh_d = load ? load_data : hs ? sh_q << 8 : sh_q;
    cnt_d = load ? 2'd0 : cnt_q + {1'b0, hs};
    vld_d = load || (vld_q && !done);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sh_q <= '0;
      cnt_q <= '0;
      vld_q <= 1'b0;
    end else begin
      sh_q <= sh_d;
      cnt_q <= cnt_d;
      vld_q <= vld_d;
    end
endmodule

// File: rtl/aes_byte_bridge.sv
// aes_byte_bridge: byte-framed front end driving the aes register interface (burst option: AES_BRIDGE_AUTOINC_EN)
module aes_byte_bridge
  import aes_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        cs,
  output logic        we,
  output logic [7:0]  address,
  output logic [31:0] write_data,
  input  logic [31:0] read_data,
  output logic        busy,
  output logic        frame_err
);
  state_e state_q, state_d;
  logic up_q, up_d;
  logic wr_q, wr_d;
  logic err_q, err_d;
  logic [7:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0] cnt_q, cnt_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [CMD_BURST_W-1:0] left_q, left_d;
  logic rx_hs, tx_done, expired;
  assign rx_ready = up_q && (state_q == IDLE || state_q == ADDR || state_q == WDATA);
  assign rx_hs = rx_valid && rx_ready;
  assign expired = TIMEOUT_CYCLES != 0 && !rx_hs && to_q == TO_W'(TIMEOUT_CYCLES - 1);
  assign cs = state_q == ACCESS;
  assign we = cs && wr_q;
  assign address = addr_q;
  assign write_data = wdata_q;
  assign busy = state_q != IDLE;
  assign frame_err = err_q;
  aes_bridge_txser u_txser (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (cs && !wr_q),
    .load_data (read_data),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .done      (tx_done)
  );
  always_comb begin
    state_d = state_q;
    up_d = 1'b1;
    wr_d = wr_q;
    err_d = err_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    cnt_d = '0;
    to_d = '0;
    left_d = left_q;
    case (state_q)
      IDLE:
        if (rx_hs) begin
          if (rx_data[CMD_RSV_MSB:CMD_RSV_LSB] != '0) err_d = 1'b1;
          else begin
            err_d = 1'b0;
            wr_d = rx_data[CMD_WR_BIT];
`ifdef AES_BRIDGE_AUTOINC_EN
            left_d = rx_data[CMD_BURST_W-1:0];
`else
            left_d = '0;
`endif
            state_d = ADDR;
          end
        end
      ADDR:
        if (rx_hs) begin
          addr_d = rx_data;
          state_d = wr_q ? WDATA : ACCESS;
        end else if (expired) begin
          err_d = 1'b1;
          state_d = IDLE;
        end else to_d = to_q + 1'b1;
      WDATA:
        if (rx_hs) begin
          wdata_d = {wdata_q[23:0], rx_data};
          cnt_d = cnt_q + 2'd1;
          state_d = cnt_q == 2'(BYTES_PER_WORD - 1) ? ACCESS : WDATA;
        end else if (expired) begin
          err_d = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q;
          to_d = to_q + 1'b1;
        end
      ACCESS:
        if (!wr_q) state_d = TX;
        else if (left_q != '0) begin
          left_d = left_q - 1'b1;
          addr_d = addr_q + 8'd1;
          state_d = WDATA;
        end else state_d = IDLE;
      TX:
        if (tx_done) begin
          if (left_q != '0) begin
            left_d = left_q - 1'b1;
            addr_d = addr_q + 8'd1;
            state_d = ACCESS;
          end else state_d = IDLE;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      up_q <= 1'b0;
      wr_q <= 1'b0;
      err_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      cnt_q <= '0;
      to_q <= '0;
      left_q <= '0;
    end else begin
      state_q <= state_d;
      up_q <= up_d;
      wr_q <= wr_d;
      err_q <= err_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      cnt_q <= cnt_d;
      to_q <= to_d;
      left_q <= left_d;
    end
endmodule

// File: tb/tb_aes_byte_bridge.sv
// tb_aes_byte_bridge: frame-level reference model bench for aes_byte_bridge (honours AES_BRIDGE_AUTOINC_EN)
module tb_aes_byte_bridge;
  localparam int TO = 8;
  logic clk, reset_n;
  logic [7:0] rx_data, tx_data, address;
  logic rx_valid, rx_ready, tx_valid, tx_ready, cs, we, busy, frame_err;
  logic [31:0] write_data, read_data;
  int n_chk = 0, n_fail = 0;
  int tx_mode = 0, rd_sel = 0;
  logic [31:0] rd_fixed = '0;
  int phase = 0, cnt = 0, idle = 0, txcnt = 0, left = 0;
  logic m_wr = 0, m_err = 0, up = 0, hs_rx, hs_tx;
  logic [7:0] m_addr = '0;
  logic [31:0] m_wd = '0, m_tx = '0;
  logic stall_q = 0;
  logic [7:0] stall_d = '0;
  int cs_cnt = 0;
  logic [7:0] last_addr = '0;
  logic [31:0] last_wd = '0;
  logic last_we = 0;
  logic [7:0] got_tx[$];
  logic [7:0] cs_addrs[$];
  function automatic logic [31:0] rd_fn(input int sel, input logic [31:0] fixed, input logic [7:0] a);
    return sel == 0 ? fixed : sel == 1 ? {24'h0, a} : {a, a ^ 8'hA5, ~a, 8'h3C};
  endfunction
  assign read_data = rd_fn(rd_sel, rd_fixed, address);
  aes_byte_bridge #(.TIMEOUT_CYCLES(TO), .TO_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .cs(cs), .we(we),
    .address(address), .write_data(write_data), .read_data(read_data), .busy(busy), .frame_err(frame_err)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  initial begin
    tx_ready = 1;
    forever begin
      @(negedge clk);
      tx_ready = tx_mode == 0 ? 1'b1 : tx_mode == 1 ? ~tx_ready : 1'($urandom % 2);
    end
  end
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase = 0; cnt = 0; idle = 0; txcnt = 0; left = 0;
      m_wr = 0; m_err = 0; up = 0; m_addr = '0; m_wd = '0; stall_q = 0;
    end else begin
      if (tx_valid && tx_ready) got_tx.push_back(tx_data);
      stall_q = tx_valid && !tx_ready;
      stall_d = tx_data;
      hs_rx = rx_valid && up && phase <= 2;
      hs_tx = phase == 4 && tx_ready;
      if (phase == 0 && hs_rx) begin
        if (rx_data[6:4] != 3'd0) m_err = 1;
        else begin
          m_err = 0;
          m_wr = rx_data[7];
`ifdef AES_BRIDGE_AUTOINC_EN
          left = int'(rx_data[3:0]);
`else
          left = 0;
`endif
          phase = 1; idle = 0;
        end
      end else if (phase == 1 || phase == 2) begin
        if (hs_rx) begin
          idle = 0;
          if (phase == 1) begin
            m_addr = rx_data;
            phase = m_wr ? 2 : 3;
            cnt = 0;
          end else begin
            m_wd = {m_wd[23:0], rx_data};
            cnt++;
            if (cnt == 4) phase = 3;
          end
        end else begin
          idle++;
          if (idle == TO) begin phase = 0; m_err = 1; end
        end
      end else if (phase == 3) begin
        if (!m_wr) begin
          m_tx = rd_fn(rd_sel, rd_fixed, m_addr);
          txcnt = 0; phase = 4;
        end else if (left > 0) begin
          left--; m_addr = m_addr + 8'd1; phase = 2; cnt = 0; idle = 0;
        end else phase = 0;
      end else if (phase == 4 && hs_tx) begin
        txcnt++;
        if (txcnt == 4) begin
          if (left > 0) begin left--; m_addr = m_addr + 8'd1; phase = 3; end
          else phase = 0;
        end
      end
      up = 1;
    end
  end
  always @(negedge clk) begin
    chk("rx_ready", rx_ready, up && phase <= 2);
    chk("busy", busy, phase != 0);
    chk("cs", cs, phase == 3);
    chk("we", we, phase == 3 && m_wr);
    chk("address", address, m_addr);
    chk("write_data", write_data, m_wd);
    chk("frame_err", frame_err, m_err);
    chk("tx_valid", tx_valid, phase == 4);
    if (phase == 4) chk("tx_data", tx_data, 8'(m_tx >> (8 * (3 - txcnt))));
    if (stall_q) begin
      chk("tx_hold_valid", tx_valid, 1);
      chk("tx_hold_data", tx_data, stall_d);
    end
    if (cs) begin
      cs_cnt++; last_addr = address; last_wd = write_data; last_we = we;
      cs_addrs.push_back(address);
    end
  end
  task automatic send(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    rx_data = b;
    rx_valid = 1;
    while (!rx_ready && n < 2000) begin @(negedge clk); n++; end
    chk("rx_accept", rx_ready, 1);
    @(posedge clk);
    #1 rx_valid = 0;
  endtask
  task automatic gap(input int g);
    repeat (g) @(posedge clk);
  endtask
  task automatic wait_idle(input int bound);
    int n = 0;
    @(negedge clk);
    while (busy && n < bound) begin @(negedge clk); n++; end
    chk("idle_reached", busy, 0);
  endtask
  initial begin
    int n0, words;
    logic [7:0] cmd;
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int n0, words;
    logic [7:0] cmd;
    reset_n = 1; rx_valid = 0; rx_data = '0;
    #1 reset_n = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_cs", cs, 0);
    reset_n = 1;
    #1 chk("first_cycle_rx_ready", rx_ready, 0);
    @(negedge clk);
    chk("rx_ready_up", rx_ready, 1);
    n0 = cs_cnt;
    send(8'h80); send(8'h10); send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
    wait_idle(50);
    chk("wr_cs_count", cs_cnt - n0, 1);
    chk("wr_addr", last_addr, 8'h10);
    chk("wr_data", last_wd, 32'hDEADBEEF);
    chk("wr_we", last_we, 1);
    rd_sel = 0; rd_fixed = 32'h01234567; tx_mode = 1; got_tx.delete(); n0 = cs_cnt;
    send(8'h00); send(8'h0C);
    wait_idle(100);
    chk("rd_cs_count", cs_cnt - n0, 1);
    chk("rd_addr", last_addr, 8'h0C);
    chk("rd_we", last_we, 0);
    chk("rd_bytes", got_tx.size(), 4);
    if (got_tx.size() == 4) chk("rd_word", {got_tx[0], got_tx[1], got_tx[2], got_tx[3]}, 32'h01234567);
    tx_mode = 0; n0 = cs_cnt;
    send(8'h90);
    chk("bad_err", frame_err, 1);
    @(negedge clk);
    chk("bad_no_cs", cs_cnt - n0, 0);
    send(8'h00);
    chk("err_cleared", frame_err, 0);
    send(8'h00);
    wait_idle(100);
    n0 = cs_cnt;
    send(8'h80); send(8'h20); send(8'hAA);
    repeat (TO) @(posedge clk);
    #1 chk("to_err", frame_err, 1);
    chk("to_idle", busy, 0);
    chk("to_no_cs", cs_cnt - n0, 0);
    send(8'h80); send(8'h21); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    wait_idle(50);
    chk("to_next_addr", last_addr, 8'h21);
    chk("to_next_data", last_wd, 32'h11223344);
    send(8'h80); send(8'h30); send(8'h01); send(8'h02);
    @(posedge clk);
    #2 reset_n = 0;
    #1 chk("arst_cs", cs, 0);
    chk("arst_busy", busy, 0);
    chk("arst_rx_ready", rx_ready, 0);
    chk("arst_address", address, 0);
    chk("arst_wdata", write_data, 0);
    chk("arst_tx_valid", tx_valid, 0);
    repeat (2) @(negedge clk);
    reset_n = 1;
    n0 = cs_cnt;
    send(8'h80); send(8'h31); send(8'hCA); send(8'hFE); send(8'hF0); send(8'h0D);
    wait_idle(50);
    chk("arst_one_cs", cs_cnt - n0, 1);
    chk("arst_wdata_new", last_wd, 32'hCAFEF00D);
`ifdef AES_BRIDGE_AUTOINC_EN
    rd_sel = 1; got_tx.delete(); cs_addrs.delete(); tx_mode = 2;
    send(8'h01); send(8'hFF);
    wait_idle(200);
    chk("ai_cs_count", cs_addrs.size(), 2);
    if (cs_addrs.size() == 2) begin
      chk("ai_addr0", cs_addrs[0], 8'hFF);
      chk("ai_addr1", cs_addrs[1], 8'h00);
    end
    chk("ai_bytes", got_tx.size(), 8);
    if (got_tx.size() == 8) begin
      chk("ai_word0", {got_tx[0], got_tx[1], got_tx[2], got_tx[3]}, 32'h000000FF);
      chk("ai_word1", {got_tx[4], got_tx[5], got_tx[6], got_tx[7]}, 32'h00000000);
    end
`endif
    rd_sel = 2; tx_mode = 2;
    for (int f = 0; f < 60; f++) begin
      cmd = 8'($urandom);
      cmd[6:4] = ($urandom % 10 == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
`ifdef AES_BRIDGE_AUTOINC_EN
      cmd[3:2] = 2'd0;
      words = int'(cmd[1:0]) + 1;
`else
      words = 1;
`endif
      send(cmd);
      if (cmd[6:4] == 3'd0) begin
        gap($urandom % 3);
        send(8'($urandom));
        if (cmd[7])
          for (int w = 0; w < 4 * words; w++) begin
            gap(($urandom % 12 == 0) ? TO + 1 : int'($urandom % 3));
            send(8'($urandom));
          end
      end
      gap($urandom % 3);
    end
    wait_idle(2000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
